// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine
//   Output-stationary ROWS x COLS systolic array that computes C = A * B.
//   A is streamed in one column per beat and B one row per beat, for k_len
//   beats. The block then flushes the array and drains C one row at a time.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   start      begins a job when sampled high in IDLE (k_len sampled with it)
//   k_len      inner dimension of the job (0..K_MAX)
//   in_valid   operand beat offered
//   in_ready   operand beat can be taken (LOAD only)
//   a_col      column k of A, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_row      row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  result row offered (DRAIN only)
//   out_ready  result row taken
//   out_row    row out_idx of C, element j at [j*ACC_WIDTH +: ACC_WIDTH]
//   out_idx    row index of out_row
//   busy       high whenever the FSM is outside IDLE
//   done       one-cycle pulse after the last row has been taken
//
// Build option
//   SYSTOLIC_SIGNED_EN  when defined, operands and accumulators are two's
//                       complement and products are sign-extended; otherwise
//                       everything is unsigned and products are zero-extended.
module systolic_mm_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K_MAX)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(K_MAX+1)-1:0]      k_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]      a_col,
  input  logic [COLS*DATA_WIDTH-1:0]      b_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COLS*ACC_WIDTH-1:0]       out_row,
  output logic [$clog2(ROWS)-1:0]         out_idx,
  output logic                            busy,
  output logic                            done
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int IW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS+COLS);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k_lat, k_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            done_q;
  logic            accept;
  logic            acc_clear;

  // Skewed operands at the array edge, each with its valid tag
  logic [DATA_WIDTH-1:0] a_sk  [ROWS];
  logic                  a_skv [ROWS];
  logic [DATA_WIDTH-1:0] b_sk  [COLS];
  logic                  b_skv [COLS];

  // Values leaving each PE towards its right / lower neighbour, and results
  logic [DATA_WIDTH-1:0] a_pass   [ROWS][COLS];
  logic                  a_pass_v [ROWS][COLS];
  logic [DATA_WIDTH-1:0] b_pass   [ROWS][COLS];
  logic                  b_pass_v [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_all  [ROWS][COLS];

  assign accept    = in_valid && in_ready;
  assign acc_clear = (state == IDLE) && start;
  assign done      = done_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and handshake outputs. A zero-length job has nothing
  // to load or flush, so it goes straight to DRAIN with cleared accumulators.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_n = (k_len == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (k_cnt + KW'(1) == k_lat)) state_n = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FW'(ROWS+COLS-2)) state_n = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (out_idx == IW'(ROWS-1))) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Job counters, drain row index and the done pulse. done is registered so
  // it appears in the IDLE cycle right after the last row handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_lat     <= '0;
      k_cnt     <= '0;
      flush_cnt <= '0;
      out_idx   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_lat     <= k_len;
            k_cnt     <= '0;
            flush_cnt <= '0;
            out_idx   <= '0;
          end
        end
        LOAD:  if (accept) k_cnt <= k_cnt + KW'(1);
        FLUSH: flush_cnt <= flush_cnt + FW'(1);
        DRAIN: begin
          if (out_ready) begin
            if (out_idx == IW'(ROWS-1)) begin
              out_idx <= '0;
              done_q  <= 1'b1;
            end else begin
              out_idx <= out_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Row i of A is delayed i cycles before entering the array so that A[i][k]
  // meets B[k][j] at PE(i,j) in the same cycle. Non-accepted cycles shift in
  // tag-0 bubbles.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    if (gi == 0) begin : g_direct
      assign a_sk[0]  = a_col[0 +: DATA_WIDTH];
      assign a_skv[0] = accept;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] d [gi];
      logic                  v [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[0] <= a_col[gi*DATA_WIDTH +: DATA_WIDTH];
          v[0] <= accept;
          for (int s = 1; s < gi; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign a_sk[gi]  = d[gi-1];
      assign a_skv[gi] = v[gi-1];
    end
  end

  // Column j of B is delayed j cycles, mirroring the A skew
  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    if (gj == 0) begin : g_direct
      assign b_sk[0]  = b_row[0 +: DATA_WIDTH];
      assign b_skv[0] = accept;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] d [gj];
      logic                  v [gj];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gj; s++) begin
            d[s] <= '0;
            v[s] <= 1'b0;
          end
        end else begin
          d[0] <= b_row[gj*DATA_WIDTH +: DATA_WIDTH];
          v[0] <= accept;
          for (int s = 1; s < gj; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign b_sk[gj]  = d[gj-1];
      assign b_skv[gj] = v[gj-1];
    end
  end

  // Processing elements: forward A right and B down through one register
  // each, and accumulate only when both operands carry a valid tag.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in, a_q, b_q;
      logic                  a_v_in, b_v_in, a_v_q, b_v_q;
      logic [ACC_WIDTH-1:0]  acc_q, prod_ext;

      if (gj == 0) begin : g_a_edge
        assign a_in   = a_sk[gi];
        assign a_v_in = a_skv[gi];
      end else begin : g_a_int
        assign a_in   = a_pass[gi][gj-1];
        assign a_v_in = a_pass_v[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in   = b_sk[gj];
        assign b_v_in = b_skv[gj];
      end else begin : g_b_int
        assign b_in   = b_pass[gi-1][gj];
        assign b_v_in = b_pass_v[gi-1][gj];
      end

`ifdef SYSTOLIC_SIGNED_EN
      logic signed [2*DATA_WIDTH-1:0] prod;
      assign prod     = $signed(a_in) * $signed(b_in);
      assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
`else
      logic [2*DATA_WIDTH-1:0] prod;
      assign prod     = a_in * b_in;
      assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          a_v_q <= 1'b0;
          b_q   <= '0;
          b_v_q <= 1'b0;
          acc_q <= '0;
        end else begin
          a_q   <= a_in;
          a_v_q <= a_v_in;
          b_q   <= b_in;
          b_v_q <= b_v_in;
          if (acc_clear)            acc_q <= '0;
          else if (a_v_in && b_v_in) acc_q <= acc_q + prod_ext;
        end
      end

      assign a_pass[gi][gj]   = a_q;
      assign a_pass_v[gi][gj] = a_v_q;
      assign b_pass[gi][gj]   = b_q;
      assign b_pass_v[gi][gj] = b_v_q;
      assign acc_all[gi][gj]  = acc_q;
    end
  end

  // Result row mux; zero outside DRAIN so idle and reset outputs are clean
  always_comb begin
    out_row = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < COLS; j++) begin
        out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_all[out_idx][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine
//   Directed self-checking bench for systolic_mm_engine with default
//   parameters (8x8 array, 8-bit operands, 20-bit accumulators). Expected
//   results are closed-form values of the directed operand patterns.
module tb_systolic_mm_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int AW   = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [4:0]           k_len = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   a_col = '0;
  logic [COLS*DW-1:0]   b_row = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [COLS*AW-1:0]   out_row;
  logic [2:0]           out_idx;
  logic                 busy;
  logic                 done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_snap = 0;

  systolic_mm_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock and a cycle counter for latency measurement
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count done pulses away from the active edge
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  // Single comparison point: counts the check, reports on mismatch
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load operand buses for a pattern: 1 -> A=i+1,B=j+1; 4 -> A=FF,B=02; 5 -> A=1,B=1
  task automatic applyStimulus(input int mode);
    for (int i = 0; i < ROWS; i++) begin
      case (mode)
        1:       a_col[i*DW +: DW] = 8'(i + 1);
        4:       a_col[i*DW +: DW] = 8'hFF;
        default: a_col[i*DW +: DW] = 8'h01;
      endcase
    end
    for (int j = 0; j < COLS; j++) begin
      case (mode)
        1:       b_row[j*DW +: DW] = 8'(j + 1);
        4:       b_row[j*DW +: DW] = 8'h02;
        default: b_row[j*DW +: DW] = 8'h01;
      endcase
    end
  endtask

  // Expected C element for each scenario
  function automatic logic [AW-1:0] expC(input int scen, input int i, input int j);
    case (scen)
      1: return AW'(8 * (i + 1) * (j + 1));
`ifdef SYSTOLIC_SIGNED_EN
      4: return 20'hFFFF0;
`else
      4: return AW'(4080);
`endif
      5: return AW'(1);
      default: return AW'(0);
    endcase
  endfunction

  // Pulse start for one cycle; leaves us #1 into the first post-start cycle
  task automatic startJob(input int k);
    start = 1'b1;
    k_len = 5'(k);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer n beats; with gap set, a bubble cycle follows each beat
  task automatic sendBeats(input int n, input bit gap);
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      for (int t = 0; t < 50 && in_ready !== 1'b1; t++) begin
        @(posedge clk); #1;
      end
      checkOutput("in_ready_beat", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Take all rows in order, optionally stalling 5 cycles at stall_row
  task automatic collectRows(input int scen, input int stall_row);
    out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int t = 0; t < 200 && out_valid !== 1'b1; t++) begin
        @(posedge clk); #1;
      end
      checkOutput("out_valid", 64'(out_valid), 64'd1);
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          checkOutput("stall_idx", 64'(out_idx), 64'(r));
          for (int j = 0; j < COLS; j++)
            checkOutput("stall_row", 64'(out_row[j*AW +: AW]), 64'(expC(scen, r, j)));
        end
        out_ready = 1'b1;
      end
      checkOutput("out_idx", 64'(out_idx), 64'(r));
      for (int j = 0; j < COLS; j++)
        checkOutput("c_elem", 64'(out_row[j*AW +: AW]), 64'(expC(scen, r, j)));
      @(posedge clk); #1;
    end
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("busy_after", 64'(busy), 64'd0);
    @(posedge clk); #1;
    checkOutput("done_clear", 64'(done), 64'd0);
    checkOutput("valid_after", 64'(out_valid), 64'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_out_idx", 64'(out_idx), 64'd0);
    checkOutput("rst_out_row", 64'(out_row), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: continuous beats, latency and C[i][j]=8(i+1)(j+1)
    $display("[TB] scenario 1");
    applyStimulus(1);
    startJob(8);
    checkOutput("s1_busy", 64'(busy), 64'd1);
    sendBeats(8, 1'b0);
    for (int t = 0; t < 100 && out_valid !== 1'b1; t++) begin
      @(posedge clk); #1;
    end
    checkOutput("s1_latency", 64'(cyc - start_cyc), 64'd24);
    collectRows(1, -1);

    // Scenario 2: in_valid toggled every other cycle, same results
    $display("[TB] scenario 2");
    startJob(8);
    sendBeats(8, 1'b1);
    collectRows(1, -1);

    // Scenario 3: out_ready low 5 cycles at row 3, single done pulse
    $display("[TB] scenario 3");
    done_snap = done_cnt;
    startJob(8);
    sendBeats(8, 1'b0);
    collectRows(1, 3);
    checkOutput("s3_done_count", 64'(done_cnt - done_snap), 64'd1);

    // Scenario 4: A=FF, B=02
    $display("[TB] scenario 4");
    applyStimulus(4);
    startJob(8);
    sendBeats(8, 1'b0);
    collectRows(4, -1);

    // Scenario 5: reset after the third beat, then a k_len=1 job
    $display("[TB] scenario 5");
    applyStimulus(1);
    done_snap = done_cnt;
    startJob(8);
    sendBeats(3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("s5_busy", 64'(busy), 64'd0);
    checkOutput("s5_done", 64'(done), 64'd0);
    checkOutput("s5_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    applyStimulus(5);
    startJob(1);
    checkOutput("s5_restart_busy", 64'(busy), 64'd1);
    checkOutput("s5_no_done", 64'(done_cnt - done_snap), 64'd0);
    sendBeats(1, 1'b0);
    collectRows(5, -1);

    // Scenario 6: start during FLUSH is ignored, then a k_len=0 job
    $display("[TB] scenario 6");
    applyStimulus(1);
    startJob(8);
    sendBeats(8, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1;
    k_len = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("s6_flush_in_ready", 64'(in_ready), 64'd0);
    checkOutput("s6_flush_busy", 64'(busy), 64'd1);
    collectRows(1, -1);
    startJob(0);
    checkOutput("s6_k0_in_ready", 64'(in_ready), 64'd0);
    checkOutput("s6_k0_valid", 64'(out_valid), 64'd1);
    collectRows(6, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
